mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage load/store sequencer sitting directly upstream of the MMU's data port.
//  - Turns one EX-stage load/store into a dbus_req_t: byte strobes, size, store-data lane shift.
//  - Runs the addr_ok/data_ok handshake and stalls the pipeline until it completes.
//  - Sign/zero-extends load data and hands rd/value to writeback.
//  - One outstanding access at a time.
// PARAMETERS
//  ADDR_W   32  address width (dbus_req_t.addr)
//  DATA_W   32  data width; strobe width = DATA_W/8
// PORTS
//  clk          in   1           clock
//  resetn       in   1           reset, synchronous, active-low
//  in_valid     in   1           EX presents a memory op this cycle (sampled only when !stall)
//  in_store     in   1           1=store, 0=load
//  in_funct     in   3           000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  in_addr      in   32          effective address
//  in_wdata     in   32          store data, right-aligned
//  in_rd        in   5           load destination register
//  flush        in   1           kill op in flight (exception/ERET in later stage)
//  dreq         out  dbus_req_t  request to MMU {valid, addr, size, strobe, data}
//  dresp        in   dbus_resp_t response from MMU {addr_ok, data_ok, data}
//  stall        out  1           hold EX/MEM pipeline registers
//  wb_valid     out  1           one-cycle pulse: access completed, not flushed
//  wb_rd        out  5           destination (0 for stores)
//  wb_data      out  32          extended load data (0 for stores)
//  exc_valid    out  1           one-cycle pulse: address error
//  exc_store    out  1           1=AdES, 0=AdEL (valid with exc_valid)
//  exc_badvaddr out  32          faulting address
// BEHAVIOUR
//  Reset: state=IDLE; dreq='0; stall=0; wb_valid=0; wb_rd=0; wb_data=0; exc_*=0.
//  FSM IDLE -> REQ -> WAIT -> IDLE; DROP = flushed access still draining.
//  - IDLE: in_valid && !flush && aligned: latch op; drive dreq.valid=1 next cycle; go REQ.
//  - REQ: dreq held constant until dresp.addr_ok.
//    addr_ok && data_ok same cycle -> complete, go IDLE.
//    addr_ok only -> go WAIT; dreq.valid drops the cycle after addr_ok.
//  - WAIT: dreq.valid=0; on data_ok -> complete, go IDLE.
//  - Complete: wb_valid=1 for the following cycle with registered wb_rd/wb_data.
//  - stall=1 in REQ/WAIT/DROP and in IDLE when a new op is accepted; deasserts the cycle of completion.
//  - Latency: best case accept->wb_valid = 2 cycles (addr_ok and data_ok in the first REQ cycle).
//  Request encoding
//  - size: B=MSIZE1, H=MSIZE2, W=MSIZE4.
//  - addr: passed through unmodified.
//  - strobe: B -> 4'b0001<<a[1:0]; H -> 4'b0011<<a[1:0]; W -> 4'b1111; loads -> 4'b0000.
//  - data: in_wdata replicated into lanes (B: {4{b}}, H: {2{h}}, W: as-is).
//  Load extension: byte/half selected by addr[1:0] from dresp.data. B/H sign-extend; BU/HU zero-extend.
//  Alignment: H requires a[0]=0; W requires a[1:0]=0.
//  Flush
//  - In IDLE: op not accepted.
//  - In REQ: request NOT withdrawn; go DROP; complete handshake, no wb_valid.
//  - In WAIT: go DROP.
//  - DROP exits to IDLE on data_ok. stall stays 1 until then (bus must quiesce).
//  - flush and completion in the same cycle: flush wins, wb_valid suppressed.
//  data_ok never arrives before addr_ok; if seen in IDLE it is ignored.
//  Reset mid-access: all state cleared immediately; the MMU is reset together, no drain.
// CONFIGURATION
//  MEM_UNALIGNED_EXC_EN defined
//  - Misaligned op: no bus request.
//  - exc_valid pulses the cycle after acceptance; exc_badvaddr=in_addr; exc_store=in_store.
//  - stall held 1 cycle; wb_valid=0.
//  Undefined
//  - Misaligned address forced aligned (H clears a[0], W clears a[1:0]); access proceeds.
//  - exc_* tied 0.
// TESTING
//  1. lw 0x8000_0004; addr_ok+data_ok in first REQ cycle, data 0xDEAD_BEEF -> wb_valid @+2, wb_data=0xDEAD_BEEF.
//  2. sb 0x1000_0003, wdata 0x0000_00A5 -> strobe=4'b1000, data=0xA5A5_A5A5, size=MSIZE1; addr_ok delayed 3 cycles -> dreq stable throughout.
//  3. lb/lbu 0x...02, rdata 0x00F0_0000 -> lb wb_data=0xFFFF_FFF0; lbu wb_data=0x0000_00F0.
//  4. lh issued, addr_ok, flush in WAIT, data_ok 2 cycles later -> no wb_valid; stall drops after data_ok.
//  5. lw 0x...02 with MEM_UNALIGNED_EXC_EN -> exc_valid=1, exc_store=0, badvaddr=0x...02, dreq.valid stays 0; without the macro -> request addr 0x...00.
//  6. Back-to-back sw then lw, zero-wait responses -> second dreq.valid one cycle after first completion; no lost or duplicated access.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer in front of the MMU data port.
// Builds the bus request, runs the addr_ok/data_ok handshake with one access in flight,
// extends load data and hands the result to writeback.
// Build option: define MEM_UNALIGNED_EXC_EN to raise AdEL/AdES on misaligned accesses;
// without it, misaligned addresses are forced aligned and the exc_* outputs stay 0.

package mem_access_pkg;
    localparam int MAU_ADDR_W = 32;
    localparam int MAU_DATA_W = 32;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef struct packed {
        logic                      valid;
        logic [MAU_ADDR_W-1:0]     addr;
        msize_t                    size;
        logic [MAU_DATA_W/8-1:0]   strobe;
        logic [MAU_DATA_W-1:0]     data;
    } dbus_req_t;

    typedef struct packed {
        logic                      addr_ok;
        logic                      data_ok;
        logic [MAU_DATA_W-1:0]     data;
    } dbus_resp_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = MAU_ADDR_W,
    parameter int DATA_W = MAU_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              in_store,
    input  logic [2:0]        in_funct,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_valid,
    output logic              exc_store,
    output logic [ADDR_W-1:0] exc_badvaddr
);

    // state  | meaning
    // S_IDLE | no access in flight; accepts a new op from EX
    // S_REQ  | request on the bus, waiting for addr_ok
    // S_WAIT | address accepted, waiting for data_ok
    // S_DROP | flushed access still draining; result discarded
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t            state_q, state_d;
    dbus_req_t         req_q, req_d, req_new;
    logic              store_q, store_d;
    logic [2:0]        funct_q, funct_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              done;
    logic              exc_block;
    logic              exc_take;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_ext;

`ifdef MEM_UNALIGNED_EXC_EN
    logic              misaligned;
    logic              exc_valid_q, exc_valid_d;
    logic              exc_store_q, exc_store_d;
    logic [ADDR_W-1:0] exc_badvaddr_q, exc_badvaddr_d;

    assign misaligned = (in_funct[1:0] == 2'b01) ? in_addr[0]
                      : ((in_funct[1:0] != 2'b00) && (|in_addr[1:0]));
    // While the exception pulse is out, the faulting op is still presented; don't retake it.
    assign exc_block  = exc_valid_q;
    assign exc_take   = misaligned;
`else
    assign exc_block  = 1'b0;
    assign exc_take   = 1'b0;
`endif

    // Encode the EX op as a bus request: size, aligned address, lane strobes, replicated data
    always_comb begin
        req_new       = '0;
        req_new.valid = 1'b1;
        req_new.addr  = in_addr;
        case (in_funct[1:0])
            2'b00: begin
                req_new.size   = MSIZE1;
                req_new.data   = {4{in_wdata[7:0]}};
                req_new.strobe = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                req_new.size    = MSIZE2;
                req_new.addr[0] = 1'b0;
                req_new.data    = {2{in_wdata[15:0]}};
                req_new.strobe  = 4'b0011 << {in_addr[1], 1'b0};
            end
            default: begin
                req_new.size      = MSIZE4;
                req_new.addr[1:0] = 2'b00;
                req_new.data      = in_wdata;
                req_new.strobe    = 4'b1111;
            end
        endcase
        if (!in_store) begin
            req_new.strobe = 4'b0000;
        end
    end

    // Select the addressed byte/half of the response and sign- or zero-extend it
    always_comb begin
        case (req_q.addr[1:0])
            2'd0:    ld_byte = dresp.data[7:0];
            2'd1:    ld_byte = dresp.data[15:8];
            2'd2:    ld_byte = dresp.data[23:16];
            default: ld_byte = dresp.data[31:24];
        endcase
        ld_half = req_q.addr[1] ? dresp.data[31:16] : dresp.data[15:0];
        case (funct_q[1:0])
            2'b00:   load_ext = funct_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = funct_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = dresp.data;
        endcase
    end

    // Sequencer next state, stall and writeback capture
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        store_d    = store_q;
        funct_d    = funct_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        stall      = 1'b0;
`ifdef MEM_UNALIGNED_EXC_EN
        exc_valid_d    = 1'b0;
        exc_store_d    = exc_store_q;
        exc_badvaddr_d = exc_badvaddr_q;
`endif
        // data_ok can only follow (or coincide with) addr_ok, so once valid has dropped
        // a bare data_ok finishes the access.
        done = (state_q != S_IDLE) && dresp.data_ok && (dresp.addr_ok || !req_q.valid);

        if (req_q.valid && dresp.addr_ok) begin
            req_d.valid = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush && !exc_block) begin
                    stall = 1'b1;
                    if (exc_take) begin
`ifdef MEM_UNALIGNED_EXC_EN
                        exc_valid_d    = 1'b1;
                        exc_store_d    = in_store;
                        exc_badvaddr_d = in_addr;
`endif
                    end else begin
                        req_d   = req_new;
                        store_d = in_store;
                        funct_d = in_funct;
                        rd_d    = in_rd;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                stall = !done;
                if (done) begin
                    state_d    = S_IDLE;
                    wb_valid_d = !flush;
                end else if (flush) begin
                    state_d = S_DROP;
                end else if (dresp.addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                stall = !done;
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wb_valid_d) begin
            wb_rd_d   = store_q ? 5'd0 : rd_q;
            wb_data_d = store_q ? '0 : load_ext;
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            store_q    <= 1'b0;
            funct_q    <= 3'b000;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            store_q    <= store_d;
            funct_q    <= funct_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

`ifdef MEM_UNALIGNED_EXC_EN
    // Address-error pulse registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exc_valid_q    <= 1'b0;
            exc_store_q    <= 1'b0;
            exc_badvaddr_q <= '0;
        end else begin
            exc_valid_q    <= exc_valid_d;
            exc_store_q    <= exc_store_d;
            exc_badvaddr_q <= exc_badvaddr_d;
        end
    end

    assign exc_valid    = exc_valid_q;
    assign exc_store    = exc_store_q;
    assign exc_badvaddr = exc_badvaddr_q;
`else
    assign exc_valid    = 1'b0;
    assign exc_store    = 1'b0;
    assign exc_badvaddr = '0;
`endif

    assign dreq     = req_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized ops with random bus
// latencies and flushes, compared against an arithmetic reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_store;
    logic [2:0]  in_funct;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        flush;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic        exc_store;
    logic [31:0] exc_badvaddr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_store     (in_store),
        .in_funct     (in_funct),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .flush        (flush),
        .dreq         (dreq),
        .dresp        (dresp),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_valid    (exc_valid),
        .exc_store    (exc_store),
        .exc_badvaddr (exc_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sz_bytes(input logic [2:0] fn);
        return 1 << fn[1:0];
    endfunction

    function automatic logic [31:0] al_addr(input logic [31:0] addr, input logic [2:0] fn);
        return addr & ~(32'(sz_bytes(fn)) - 32'd1);
    endfunction

    function automatic msize_t model_size(input logic [2:0] fn);
        case (sz_bytes(fn))
            1:       return MSIZE1;
            2:       return MSIZE2;
            default: return MSIZE4;
        endcase
    endfunction

    function automatic logic [3:0] model_strobe(input logic st, input logic [2:0] fn, input logic [31:0] addr);
        int lane;
        logic [7:0] m;
        if (!st) return 4'b0000;
        lane = int'(al_addr(addr, fn) % 4);
        m = 8'((1 << sz_bytes(fn)) - 1) << lane;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] fn, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = sz_bytes(fn);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int lane;
        lane = int'(al_addr(addr, fn) % 4);
        v = rdata >> (8 * lane);
        case (sz_bytes(fn))
            1: v = fn[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2: v = fn[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    // One op from EX to writeback. addr_ok arrives aok cycles into the request, data_ok dok
    // cycles after that; fl is the request-phase cycle carrying flush (-1: none).
    task automatic run_op(input logic st, input logic [2:0] fn, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int aok,
                          input int dok, input int fl, input logic [31:0] rdata);
        int c;
        bit killed;
        bit mis;
        mis      = (addr != al_addr(addr, fn));
        in_valid = 1'b1;
        in_store = st;
        in_funct = fn;
        in_addr  = addr;
        in_wdata = wd;
        in_rd    = rd;
        flush    = 1'b0;
        dresp    = '0;
        #1;
        check("accept_stall", stall, 1);
        @(posedge clk);
        @(negedge clk);
`ifdef MEM_UNALIGNED_EXC_EN
        if (mis) begin
            #1;
            check("exc_valid", exc_valid, 1);
            check("exc_store", exc_store, st);
            check("exc_badvaddr", exc_badvaddr, addr);
            check("exc_no_req", dreq.valid, 0);
            check("exc_stall", stall, 0);
            check("exc_no_wb", wb_valid, 0);
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            #1;
            check("exc_pulse_end", exc_valid, 0);
            check("exc_no_req2", dreq.valid, 0);
            return;
        end
`else
        if (mis) check("forced_align_addr", dreq.addr, al_addr(addr, fn));
`endif
        c      = aok + dok;
        killed = (fl >= 0) && (fl <= c);
        for (int k = 0; k <= c; k++) begin
            dresp.addr_ok = (k == aok);
            dresp.data_ok = (k == c);
            dresp.data    = (k == c) ? rdata : $urandom;
            flush         = (k == fl);
            #1;
            check("req_valid", dreq.valid, (k <= aok));
            if (k <= aok) begin
                check("req_addr", dreq.addr, al_addr(addr, fn));
                check("req_size", dreq.size, model_size(fn));
                check("req_strobe", dreq.strobe, model_strobe(st, fn, addr));
                check("req_data", dreq.data, model_wdata(fn, wd));
            end
            check("busy_stall", stall, (k < c));
            check("early_wb", wb_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        dresp    = '0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("wb_valid", wb_valid, !killed);
        if (!killed) begin
            check("wb_rd", wb_rd, st ? 5'd0 : rd);
            check("wb_data", wb_data, st ? 32'd0 : model_load(fn, addr, rdata));
        end
        check("done_stall", stall, 0);
        check("done_req_idle", dreq.valid, 0);
        check("exc_quiet", exc_valid, 0);
    endtask

    logic        r_st;
    logic [2:0]  r_fn;
    logic [31:0] r_addr;
    int          r_aok, r_dok, r_fl;

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_store = 1'b0;
        in_funct = 3'b000;
        in_addr  = '0;
        in_wdata = '0;
        in_rd    = '0;
        flush    = 1'b0;
        dresp    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_valid", dreq.valid, 0);
        check("rst_req_addr", dreq.addr, 0);
        check("rst_req_strobe", dreq.strobe, 0);
        check("rst_req_data", dreq.data, 0);
        check("rst_stall", stall, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_exc_valid", exc_valid, 0);
        check("rst_exc_store", exc_store, 0);
        check("rst_exc_badvaddr", exc_badvaddr, 0);
        resetn = 1'b1;
        @(negedge clk);
        #1;

        // lw, best-case bus
        run_op(1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd7, 0, 0, -1, 32'hDEAD_BEEF);
        // sb to the top byte, addr_ok held off 3 cycles
        run_op(1'b1, 3'b000, 32'h1000_0003, 32'h0000_00A5, 5'd3, 3, 0, -1, 32'h0);
        // lb / lbu from lane 2
        run_op(1'b0, 3'b000, 32'h2000_0002, 32'h0, 5'd9, 0, 0, -1, 32'h00F0_0000);
        run_op(1'b0, 3'b100, 32'h2000_0002, 32'h0, 5'd10, 0, 0, -1, 32'h00F0_0000);
        // lh flushed while waiting for data
        run_op(1'b0, 3'b001, 32'h3000_0006, 32'h0, 5'd11, 0, 3, 1, 32'h1234_8765);
        // flush before addr_ok: request stays on the bus until accepted
        run_op(1'b0, 3'b101, 32'h3000_0002, 32'h0, 5'd12, 2, 1, 0, 32'h8001_0000);
        // flush on the completion cycle
        run_op(1'b0, 3'b010, 32'h3000_0010, 32'h0, 5'd13, 1, 0, 1, 32'h5555_AAAA);
        // misaligned lw
        run_op(1'b0, 3'b010, 32'h4000_0002, 32'h0, 5'd14, 0, 0, -1, 32'hCAFE_F00D);
        // back-to-back sw then lw, zero-wait
        run_op(1'b1, 3'b010, 32'h5000_0008, 32'h1357_9BDF, 5'd15, 0, 0, -1, 32'h0);
        run_op(1'b0, 3'b010, 32'h5000_0008, 32'h0, 5'd16, 0, 0, -1, 32'h1357_9BDF);

        // flush in IDLE rejects the op
        in_valid = 1'b1; in_store = 1'b0; in_funct = 3'b010; in_addr = 32'h6000_0000; flush = 1'b1;
        #1;
        check("idle_flush_stall", stall, 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush_noreq", dreq.valid, 0);
        check("idle_flush_stall2", stall, 0);

        // stray data_ok in IDLE is ignored
        dresp.data_ok = 1'b1; dresp.data = 32'hFFFF_FFFF;
        #1;
        check("stray_dok_stall", stall, 0);
        @(posedge clk); @(negedge clk);
        dresp = '0;
        #1;
        check("stray_dok_wb", wb_valid, 0);
        check("stray_dok_req", dreq.valid, 0);

        // reset in the middle of an access clears everything at once
        in_valid = 1'b1; in_store = 1'b0; in_funct = 3'b010; in_addr = 32'h7000_0010; in_rd = 5'd5;
        @(posedge clk); @(negedge clk);
        #1;
        check("rst_mid_req", dreq.valid, 1);
        resetn = 1'b0; in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        check("rst_mid_req_clr", dreq.valid, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_wb", wb_valid, 0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        run_op(1'b0, 3'b001, 32'h7000_0012, 32'h0, 5'd6, 1, 2, -1, 32'h8765_4321);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r_st = ($urandom_range(0, 2) == 0);
            if (r_st) begin
                r_fn = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       r_fn = 3'b000;
                    1:       r_fn = 3'b001;
                    2:       r_fn = 3'b010;
                    3:       r_fn = 3'b100;
                    default: r_fn = 3'b101;
                endcase
            end
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = al_addr(r_addr, r_fn);
            r_aok = int'($urandom_range(0, 3));
            r_dok = int'($urandom_range(0, 3));
            r_fl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, r_aok + r_dok)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
            end
            run_op(r_st, r_fn, r_addr, $urandom, 5'($urandom_range(0, 31)), r_aok, r_dok, r_fl, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
